// File: rtl/mod_cls_pkg.sv
// Shared types, mode codes and helpers for the spectrum modulation classifier.
package mod_cls_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_JUDGE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [2:0] MODE_NONE  = 3'b000;
  localparam logic [2:0] MODE_AM    = 3'b001;
  localparam logic [2:0] MODE_FM    = 3'b010;
  localparam logic [2:0] MODE_OTHER = 3'b100;

  // Distance between a sideband-pair midpoint and the carrier bin.
  function automatic int unsigned abs_diff(input int unsigned a, input int unsigned b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/peak_topn_sorter.sv
// Single-pass descending insertion sorter holding the NPK largest samples seen.
module peak_topn_sorter #(
  parameter  int unsigned DW  = 16,
  parameter  int unsigned AW  = 8,
  parameter  int unsigned NPK = 4,
  localparam int unsigned CW  = $clog2(NPK + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_clr,
  input  logic                i_vld,
  input  logic [DW-1:0]       i_mag,
  input  logic [AW-1:0]       i_addr,
  output logic [NPK*DW-1:0]   o_mag,
  output logic [NPK*AW-1:0]   o_addr,
  output logic [CW-1:0]       o_cnt
);

  logic [DW-1:0]  r_mag  [NPK];
  logic [AW-1:0]  r_addr [NPK];
  logic [CW-1:0]  r_cnt;
  logic [NPK-1:0] w_gt;
  logic [NPK-1:0] w_new;

  // Per-slot compare: empty slots or strictly smaller entries yield; ties keep the older entry.
  always_comb begin
    w_gt  = '0;
    w_new = '0;
    for (int i = 0; i < NPK; i++) begin
      w_gt[i] = (CW'(i) >= r_cnt) || (i_mag > r_mag[i]);
    end
    w_new[0] = w_gt[0];
    for (int i = 1; i < NPK; i++) begin
      w_new[i] = w_gt[i] && !w_gt[i-1];
    end
  end

  // Insert at the first yielding slot, shift the rest down, lowest entry falls off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NPK; i++) begin
        r_mag[i]  <= '0;
        r_addr[i] <= '0;
      end
      r_cnt <= '0;
    end else if (i_clr) begin
      for (int i = 0; i < NPK; i++) begin
        r_mag[i]  <= '0;
        r_addr[i] <= '0;
      end
      r_cnt <= '0;
    end else if (i_vld) begin
      if (w_gt[0]) begin
        r_mag[0]  <= i_mag;
        r_addr[0] <= i_addr;
      end
      for (int i = 1; i < NPK; i++) begin
        if (w_new[i]) begin
          r_mag[i]  <= i_mag;
          r_addr[i] <= i_addr;
        end else if (w_gt[i]) begin
          r_mag[i]  <= r_mag[i-1];
          r_addr[i] <= r_addr[i-1];
        end
      end
      if ((w_gt != '0) && (r_cnt != CW'(NPK))) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // Flatten the rank registers for the parent.
  always_comb begin
    o_mag  = '0;
    o_addr = '0;
    for (int i = 0; i < NPK; i++) begin
      o_mag[i*DW +: DW]  = r_mag[i];
      o_addr[i*AW +: AW] = r_addr[i];
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/spectrum_mod_classifier.sv
// Post-FFT modulation classifier: one windowed pass over |X|, top-N sideband sort, AM/FM judge.
module spectrum_mod_classifier
  import mod_cls_pkg::*;
#(
  parameter int unsigned DW          = 16,
  parameter int unsigned AW          = 8,
  parameter int unsigned CARRIER_BIN = 100,
  parameter int unsigned SPAN        = 100,
  parameter int unsigned NPK         = 4,
  parameter int unsigned RD_LAT      = 1,
  parameter int unsigned NOISE_TH    = 100,
  parameter int unsigned AM_SHIFT    = 3,
  parameter int unsigned SYM_TOL     = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          restart_n,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          busy,
  output logic          valid,
  output logic [2:0]    mode_type,
  output logic [DW-1:0] carrier_mag,
  output logic [3:0]    peak_cnt
);

  localparam int unsigned AMAX = (1 << AW) - 1;
  localparam int unsigned LO   = (CARRIER_BIN > SPAN) ? (CARRIER_BIN - SPAN) : 0;
  localparam int unsigned HI   = ((CARRIER_BIN + SPAN) > AMAX) ? AMAX : (CARRIER_BIN + SPAN);
  localparam int unsigned CW   = $clog2(NPK + 1);
  localparam int unsigned DCW  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int unsigned SW   = DW + AM_SHIFT;

  state_t          r_state;
  logic [DCW-1:0]  r_drain;
  logic            r_start_s1, r_start_s2, r_start_d;
  logic            r_rstrt_s1, r_rstrt_s2, r_rstrt_d;
  logic            r_pv [RD_LAT];
  logic [AW-1:0]   r_pa [RD_LAT];

  logic            w_start_rise, w_restart_fall, w_active, w_abort, w_scan_go;
  logic            w_tag_vld, w_is_carrier, w_ins_vld;
  logic [AW-1:0]   w_tag_addr;
  logic [NPK*DW-1:0] w_mag_flat;
  logic [NPK*AW-1:0] w_addr_flat;
  logic [CW-1:0]   w_cnt;
  logic [DW-1:0]   w_m0, w_m1;
  logic [AW-1:0]   w_a0, w_a1, w_a2, w_a3;
  logic [AW:0]     w_mid01, w_mid23;
  logic            w_sym01, w_sym23, w_am_ok;
  logic [2:0]      w_mode;
  logic            w_unused;

  // Two-flop synchronisers plus edge detectors for the start level and restart key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_s1 <= 1'b0;
      r_start_s2 <= 1'b0;
      r_start_d  <= 1'b0;
      r_rstrt_s1 <= 1'b1;
      r_rstrt_s2 <= 1'b1;
      r_rstrt_d  <= 1'b1;
    end else begin
      r_start_s1 <= start;
      r_start_s2 <= r_start_s1;
      r_start_d  <= r_start_s2;
      r_rstrt_s1 <= restart_n;
      r_rstrt_s2 <= r_rstrt_s1;
      r_rstrt_d  <= r_rstrt_s2;
    end
  end

  assign w_start_rise   = r_start_s2 & ~r_start_d;
  assign w_restart_fall = r_rstrt_d & ~r_rstrt_s2;
  assign w_active       = (r_state == ST_SCAN) || (r_state == ST_DRAIN) || (r_state == ST_JUDGE);
  assign w_abort        = w_restart_fall & w_active;
  assign w_scan_go      = (r_state == ST_IDLE) & w_start_rise & ~w_restart_fall;

  // Address/valid tag pipeline matching the RAM read latency; flushed on abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_pv[i] <= 1'b0;
        r_pa[i] <= '0;
      end
    end else if (w_abort) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_pv[i] <= 1'b0;
        r_pa[i] <= '0;
      end
    end else begin
      r_pv[0] <= (r_state == ST_SCAN);
      r_pa[0] <= rd_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pa[i] <= r_pa[i-1];
      end
    end
  end

  assign w_tag_vld    = r_pv[RD_LAT-1];
  assign w_tag_addr   = r_pa[RD_LAT-1];
  assign w_is_carrier = (w_tag_addr == AW'(CARRIER_BIN));
  assign w_ins_vld    = w_tag_vld & ~w_is_carrier & (rd_data > DW'(NOISE_TH));

  // Carrier magnitude capture; zeroed when a new scan begins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carrier_mag <= '0;
    end else if (w_scan_go) begin
      carrier_mag <= '0;
    end else if (w_tag_vld && w_is_carrier) begin
      carrier_mag <= rd_data;
    end
  end

  peak_topn_sorter #(
    .DW  (DW),
    .AW  (AW),
    .NPK (NPK)
  ) u_sorter (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_abort | w_scan_go),
    .i_vld  (w_ins_vld),
    .i_mag  (rd_data),
    .i_addr (w_tag_addr),
    .o_mag  (w_mag_flat),
    .o_addr (w_addr_flat),
    .o_cnt  (w_cnt)
  );

  assign w_m0 = w_mag_flat[0  +: DW];
  assign w_m1 = w_mag_flat[DW +: DW];
  assign w_a0 = w_addr_flat[0    +: AW];
  assign w_a1 = w_addr_flat[AW   +: AW];
  assign w_a2 = w_addr_flat[2*AW +: AW];
  assign w_a3 = w_addr_flat[3*AW +: AW];
  // Lower-rank magnitudes only steer the ordering, never the verdict.
  assign w_unused = ^w_mag_flat;

  // Classification of the final sorter contents.
  always_comb begin
    w_mid01 = ((AW+1)'(w_a0) + (AW+1)'(w_a1)) >> 1;
    w_mid23 = ((AW+1)'(w_a2) + (AW+1)'(w_a3)) >> 1;
    w_sym01 = abs_diff(32'(w_mid01), CARRIER_BIN) <= SYM_TOL;
    w_sym23 = abs_diff(32'(w_mid23), CARRIER_BIN) <= SYM_TOL;
    w_am_ok = ((SW'(w_m0) << AM_SHIFT) >= SW'(carrier_mag)) &&
              ((SW'(w_m1) << AM_SHIFT) >= SW'(carrier_mag));
    w_mode  = MODE_OTHER;
    if ((carrier_mag <= DW'(NOISE_TH)) && (w_cnt == '0)) begin
      w_mode = MODE_NONE;
    end else if ((w_cnt >= CW'(4)) && w_sym23) begin
      w_mode = MODE_FM;
    end else if ((w_cnt >= CW'(2)) && w_sym01 && w_am_ok) begin
      w_mode = MODE_AM;
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_drain   <= '0;
      rd_addr   <= '0;
      busy      <= 1'b0;
      valid     <= 1'b0;
      mode_type <= MODE_NONE;
      peak_cnt  <= '0;
    end else if (w_abort) begin
      r_state <= ST_IDLE;
      rd_addr <= '0;
      busy    <= 1'b0;
      valid   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_scan_go) begin
            r_state <= ST_SCAN;
            rd_addr <= AW'(LO);
            busy    <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (rd_addr == AW'(HI)) begin
            r_state <= ST_DRAIN;
            rd_addr <= '0;
            r_drain <= '0;
          end else begin
            rd_addr <= rd_addr + AW'(1);
          end
        end
        ST_DRAIN: begin
          if (r_drain == DCW'(RD_LAT - 1)) begin
            r_state <= ST_JUDGE;
          end else begin
            r_drain <= r_drain + DCW'(1);
          end
        end
        ST_JUDGE: begin
          r_state   <= ST_DONE;
          busy      <= 1'b0;
          valid     <= 1'b1;
          mode_type <= w_mode;
          peak_cnt  <= 4'(w_cnt);
        end
        ST_DONE: begin
          if (w_restart_fall) begin
            r_state   <= ST_IDLE;
            valid     <= 1'b0;
            mode_type <= MODE_NONE;
            peak_cnt  <= '0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          rd_addr <= '0;
          busy    <= 1'b0;
          valid   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spectrum_mod_classifier.sv
// Directed bench: two classifier instances (RD_LAT 1 and 3) reading one shared magnitude RAM.
module tb_spectrum_mod_classifier;

  localparam int NBINS = 201;

  logic        clk = 1'b0;
  logic        rst_n, start, restart_n;
  logic [7:0]  rd_addr1, rd_addr3;
  logic [15:0] rd_data1, rd_data3;
  logic        busy1, busy3, valid1, valid3;
  logic [2:0]  mode1, mode3;
  logic [15:0] cmag1, cmag3;
  logic [3:0]  pcnt1, pcnt3;

  logic [15:0] mem [256];
  logic [15:0] p3a, p3b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  spectrum_mod_classifier #(.RD_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .restart_n(restart_n),
    .rd_addr(rd_addr1), .rd_data(rd_data1), .busy(busy1), .valid(valid1),
    .mode_type(mode1), .carrier_mag(cmag1), .peak_cnt(pcnt1)
  );

  spectrum_mod_classifier #(.RD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .restart_n(restart_n),
    .rd_addr(rd_addr3), .rd_data(rd_data3), .busy(busy3), .valid(valid3),
    .mode_type(mode3), .carrier_mag(cmag3), .peak_cnt(pcnt3)
  );

  // RAM models with one and three cycles of read latency
  always @(posedge clk) begin
    rd_data1 <= mem[rd_addr1];
    p3a      <= mem[rd_addr3];
    p3b      <= p3a;
    rd_data3 <= p3b;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill(input int bg);
    for (int i = 0; i < 256; i++) mem[i] = 16'(bg);
  endtask

  task automatic restart_idle();
    @(negedge clk); restart_n = 1'b0;
    repeat (4) @(negedge clk);
    restart_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic run_scan(input bit glitch, output int b1, output int v1,
                          output int b3, output int v3, output int a1, output int a3);
    b1 = -1; v1 = -1; b3 = -1; v3 = -1; a1 = -1; a3 = -1;
    @(negedge clk); start = 1'b1;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (glitch && t == 40) start = 1'b0;
      if (glitch && t == 45) start = 1'b1;
      if (b1 < 0 && busy1)  begin b1 = t; a1 = int'(rd_addr1); end
      if (b3 < 0 && busy3)  begin b3 = t; a3 = int'(rd_addr3); end
      if (v1 < 0 && valid1) v1 = t;
      if (v3 < 0 && valid3) v3 = t;
      if (v1 >= 0 && v3 >= 0) break;
    end
    start = 1'b0;
  endtask

  task automatic do_case(input string tag, input int e_mode, input int e_pc, input int e_cm,
                         input bit glitch, input bit stay);
    int b1, v1, b3, v3, a1, a3;
    run_scan(glitch, b1, v1, b3, v3, a1, a3);
    chk({tag, "/lat1"}, v1 - b1, NBINS + 1 + 1);
    chk({tag, "/lat3"}, v3 - b3, NBINS + 3 + 1);
    chk({tag, "/first_addr1"}, a1, 0);
    chk({tag, "/first_addr3"}, a3, 0);
    repeat (glitch ? 10 : 2) @(negedge clk);
    chk({tag, "/valid1"}, int'(valid1), 1);
    chk({tag, "/valid3"}, int'(valid3), 1);
    chk({tag, "/busy1"},  int'(busy1), 0);
    chk({tag, "/mode1"},  int'(mode1), e_mode);
    chk({tag, "/mode3"},  int'(mode3), e_mode);
    chk({tag, "/pcnt1"},  int'(pcnt1), e_pc);
    chk({tag, "/pcnt3"},  int'(pcnt3), e_pc);
    chk({tag, "/cmag1"},  int'(cmag1), e_cm);
    chk({tag, "/cmag3"},  int'(cmag3), e_cm);
    if (!stay) begin
      restart_idle();
      chk({tag, "/clr_valid1"}, int'(valid1), 0);
      chk({tag, "/clr_mode1"},  int'(mode1), 0);
      chk({tag, "/clr_pcnt3"},  int'(pcnt3), 0);
    end
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0; start = 1'b0; restart_n = 1'b1;
    fill(0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst/busy1",  int'(busy1), 0);
    chk("rst/valid1", int'(valid1), 0);
    chk("rst/mode1",  int'(mode1), 0);
    chk("rst/cmag1",  int'(cmag1), 0);
    chk("rst/pcnt1",  int'(pcnt1), 0);
    chk("rst/addr3",  int'(rd_addr3), 0);

    // AM: symmetric sidebands well above carrier/8
    fill(20); mem[100] = 4000; mem[90] = 600; mem[110] = 600;
    do_case("am", 1, 2, 4000, 1'b0, 1'b0);

    // FM: two sideband pairs, outer pair centred on the carrier
    fill(30); mem[100] = 3000; mem[95] = 2500; mem[105] = 2500; mem[85] = 1800; mem[115] = 1800;
    do_case("fm", 2, 4, 3000, 1'b0, 1'b0);

    // weak sidebands: 400<<3 = 3200 < 4000
    fill(20); mem[100] = 4000; mem[90] = 400; mem[110] = 400;
    do_case("weak", 4, 2, 4000, 1'b0, 1'b0);

    // asymmetric: midpoint 105
    fill(20); mem[100] = 4000; mem[90] = 600; mem[120] = 600;
    do_case("asym", 4, 2, 4000, 1'b0, 1'b0);

    // AM threshold boundary: 500<<3 == 4000
    fill(20); mem[100] = 4000; mem[90] = 500; mem[110] = 500;
    do_case("am_edge", 1, 2, 4000, 1'b0, 1'b0);

    // symmetry tolerance boundary: midpoint 101
    fill(20); mem[100] = 4000; mem[90] = 600; mem[112] = 600;
    do_case("sym_edge", 1, 2, 4000, 1'b0, 1'b0);

    // noise only, including values exactly at the threshold
    fill(50); mem[100] = 100; mem[90] = 100; mem[0] = 100; mem[200] = 100; mem[201] = 9000;
    do_case("noise", 0, 0, 100, 1'b0, 1'b0);

    // start re-edge during busy is ignored; stay in DONE afterwards
    fill(20); mem[100] = 4000; mem[90] = 600; mem[110] = 600;
    do_case("glitch", 1, 2, 4000, 1'b1, 1'b1);

    // start + restart together in DONE: back to IDLE, no new scan
    @(negedge clk); start = 1'b1; restart_n = 1'b0;
    seen = 1'b0;
    repeat (30) begin @(negedge clk); if (busy1 || busy3) seen = 1'b1; end
    chk("both/busy_seen", int'(seen), 0);
    chk("both/valid1", int'(valid1), 0);
    chk("both/valid3", int'(valid3), 0);
    restart_n = 1'b1; start = 1'b0;
    repeat (4) @(negedge clk);

    // abort mid-SCAN
    @(negedge clk); start = 1'b1;
    repeat (50) @(negedge clk);
    chk("abort/busy_pre1", int'(busy1), 1);
    chk("abort/busy_pre3", int'(busy3), 1);
    restart_n = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort/busy1", int'(busy1), 0);
    chk("abort/addr1", int'(rd_addr1), 0);
    restart_n = 1'b1; start = 1'b0;
    seen = 1'b0;
    repeat (400) begin @(negedge clk); if (valid1 || valid3) seen = 1'b1; end
    chk("abort/valid_seen", int'(seen), 0);

    // asynchronous reset mid-SCAN after the carrier has been captured
    @(negedge clk); start = 1'b1;
    repeat (150) @(negedge clk);
    chk("rstmid/cmag_pre1", int'(cmag1), 4000);
    rst_n = 1'b0; start = 1'b0;
    #1;
    chk("rstmid/busy1",  int'(busy1), 0);
    chk("rstmid/addr1",  int'(rd_addr1), 0);
    chk("rstmid/cmag1",  int'(cmag1), 0);
    chk("rstmid/cmag3",  int'(cmag3), 0);
    chk("rstmid/valid3", int'(valid3), 0);
    chk("rstmid/pcnt3",  int'(pcnt3), 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // recovery scan after reset
    do_case("post_rst", 1, 2, 4000, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
